router_pkt_tx: RTL

//  Packet source for the router input port: the transmit end of the header/payload/parity protocol

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_tx_buffer.sv | 31 +++
 rtl/router_pkt_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants, tx state encoding and header helper
package router_pkg;

    localparam int DATA_W  = 8;
    localparam int LEN_W   = 6;
    localparam int ADDR_W  = 2;
    localparam int MAX_LEN = (1 << LEN_W) - 1;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_LOAD = 3'd1,
        TX_HDR  = 3'd2,
        TX_PAY  = 3'd3,
        TX_PAR  = 3'd4
    } tx_state_t;

    // Header byte carries the payload length above the destination address.
    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buffer.sv
// rtl/router_tx_buffer.sv - payload buffer, synchronous write / combinational read
// Ports:
//   clock  in   rising-edge clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write byte
//   raddr  in   read index
//   rdata  out  byte at raddr (combinational)
module router_tx_buffer
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [LEN_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LEN_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents need no reset: every byte is written before it is read.
    logic [DATA_W-1:0] mem [MAX_LEN];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - router packet source: buffer payload, then send header/payload/parity
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   start             packet request, sampled in IDLE only
//   addr, payload_len destination and byte count, latched on accepted start
//   payload_in/valid  payload byte from source; payload_ready high in LOAD
//   busy              router back-pressure, holds the presented byte
//   pkt_valid         high for header and payload bytes, low for parity byte
//   data_out          byte presented to router
//   tx_parity         running XOR of header and loaded payload
//   idle_ready        high in IDLE
//   done              pulse after parity byte is consumed
//   len_err           pulse when a zero-length start is rejected
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic [DATA_W-1:0] payload_in,
    input  logic              payload_valid,
    output logic              payload_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] tx_parity,
    output logic              idle_ready,
    output logic              done,
    output logic              len_err
);

    tx_state_t         state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  wcnt;
    // rcnt is the index of the next payload byte to present
    logic [LEN_W-1:0]  rcnt;
    logic [DATA_W-1:0] hdr_q;
    logic [DATA_W-1:0] rdata;
    logic              buf_we;

    assign buf_we = (state == TX_LOAD) && payload_valid && payload_ready;

    router_tx_buffer u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (wcnt),
        .wdata (payload_in),
        .raddr (rcnt),
        .rdata (rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= TX_IDLE;
            len_q         <= '0;
            wcnt          <= '0;
            rcnt          <= '0;
            hdr_q         <= '0;
            payload_ready <= 1'b0;
            pkt_valid     <= 1'b0;
            data_out      <= '0;
            tx_parity     <= '0;
            idle_ready    <= 1'b1;
            done          <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        if (payload_len != '0) begin
                            len_q         <= payload_len;
                            hdr_q         <= make_header(payload_len, addr);
                            tx_parity     <= make_header(payload_len, addr);
                            wcnt          <= '0;
                            rcnt          <= '0;
                            payload_ready <= 1'b1;
                            idle_ready    <= 1'b0;
                            state         <= TX_LOAD;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                TX_LOAD: begin
                    if (buf_we) begin
                        tx_parity <= tx_parity ^ payload_in;
                        if (wcnt == len_q - 1'b1) begin
                            payload_ready <= 1'b0;
                            data_out      <= hdr_q;
                            pkt_valid     <= 1'b1;
                            state         <= TX_HDR;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                TX_HDR: begin
                    if (!busy) begin
                        data_out <= rdata;
                        rcnt     <= rcnt + 1'b1;
                        state    <= TX_PAY;
                    end
                end
                TX_PAY: begin
                    if (!busy) begin
                        // rcnt == len_q means the last payload byte is being consumed
                        if (rcnt == len_q) begin
                            data_out  <= tx_parity;
                            pkt_valid <= 1'b0;
                            state     <= TX_PAR;
                        end else begin
                            data_out <= rdata;
                            rcnt     <= rcnt + 1'b1;
                        end
                    end
                end
                TX_PAR: begin
                    if (!busy) begin
                        data_out   <= '0;
                        done       <= 1'b1;
                        idle_ready <= 1'b1;
                        state      <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule
